// File: rtl/cache_set_array_pkg.sv
// Shared types for the set-associative cache core: request opcodes,
// controller state encoding and an opcode decode helper.
package cache_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_INVAL = 2'd2
  } op_t;

  // Controller state, kept as plain constants so older tools can consume it.
  typedef logic [1:0] fsm_t;
  localparam fsm_t IDLE   = 2'd0;
  localparam fsm_t LOOKUP = 2'd1;
  localparam fsm_t SWEEP  = 2'd2;
  localparam fsm_t EVICT  = 2'd3;

  // Opcode 3 is unused on the bus and behaves as a read.
  function automatic op_t decode_op(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_op = OP_WRITE;
      2'd2:    decode_op = OP_INVAL;
      default: decode_op = OP_READ;
    endcase
  endfunction

endpackage

// File: rtl/cache_set_array_if.sv
// Request / response / write-back bundle between the load-store unit,
// the cache core and the backing memory.
//
// Handshake rules: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_valid may be held high across responses to
// issue back-to-back requests. A write-back transfers on a rising edge where
// evict_valid and evict_ready are both 1; while evict_valid is high the
// evict_addr/evict_val values do not change. resp_valid is a single-cycle
// pulse with no backpressure.
interface cache_set_array_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [LINE_WIDTH-1:0] in_val;
  logic                  resp_valid;
  logic                  resp_hit;
  logic [LINE_WIDTH-1:0] out_val;
  logic                  evict_valid;
  logic                  evict_ready;
  logic [ADDR_WIDTH-1:0] evict_addr;
  logic [LINE_WIDTH-1:0] evict_val;
  logic [1:0]            dbg_state;

  modport master (
    output req_valid, req_op, in_addr, in_val, evict_ready,
    input  req_ready, resp_valid, resp_hit, out_val,
           evict_valid, evict_addr, evict_val, dbg_state
  );

  modport slave (
    input  req_valid, req_op, in_addr, in_val, evict_ready,
    output req_ready, resp_valid, resp_hit, out_val,
           evict_valid, evict_addr, evict_val, dbg_state
  );
endinterface

// File: rtl/cache_set_array_clock_victim_sel.sv
// CLOCK replacement helper for one set: lowest invalid way, whether the way
// under the hand can be replaced now, and the advanced hand position.
module clock_victim_sel #(
  parameter int K      = 2,
  parameter int HAND_W = $clog2(K)
) (
  input  logic [K-1:0]      ref_i,
  input  logic [K-1:0]      valid_i,
  input  logic [K-1:0]      dirty_i,
  input  logic [HAND_W-1:0] hand_i,
  output logic [HAND_W-1:0] first_inv_o,
  output logic              any_inv_o,
  output logic              victim_found_o,
  output logic              victim_dirty_o,
  output logic [HAND_W-1:0] next_hand_o
);

  // Scan from the top so the lowest invalid index wins.
  always_comb begin
    first_inv_o = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (!valid_i[i]) first_inv_o = HAND_W'(i);
    end
  end

  assign any_inv_o      = ~&valid_i;
  assign victim_found_o = ~ref_i[hand_i];
  assign victim_dirty_o = dirty_i[hand_i];
  // K is a power of two, so natural wrap gives the modulo.
  assign next_hand_o    = hand_i + HAND_W'(1);

endmodule

// File: rtl/cache_set_array.sv
// Set-associative cache core with per-set CLOCK replacement and a separate
// dirty write-back handshake. One request is processed at a time.
module cache_set_array
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LINE_WIDTH = 32,
  parameter int K          = 2,
  parameter int NUM_SETS   = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  cache_set_array_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W;
  localparam int HAND_W = $clog2(K);

  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [LINE_WIDTH-1:0] val;
    logic                  valid;
    logic                  dirty;
    logic                  rbit;
  } line_t;

  line_t                 lines_q [NUM_SETS][K];
  logic [HAND_W-1:0]     hand_q  [NUM_SETS];

  fsm_t                  state_q, state_d;
  op_t                   op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] val_q;
  logic                  ready_en_q;
  logic                  resp_valid_q, resp_hit_q;
  logic [LINE_WIDTH-1:0] out_val_q;
  logic                  evict_valid_q;
  logic [ADDR_WIDTH-1:0] evict_addr_q;
  logic [LINE_WIDTH-1:0] evict_val_q;
  logic [HAND_W-1:0]     victim_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [K-1:0]          valid_vec, dirty_vec, ref_vec, hit_vec;
  logic [HAND_W-1:0]     hit_way;
  logic                  hit;
  line_t                 hit_line, hand_line, fill_line;
  logic [HAND_W-1:0]     first_inv, next_hand;
  logic                  any_inv, victim_found, victim_dirty;
  logic                  accept, evict_done;

  assign idx        = addr_q[IDX_W-1:0];
  assign tag        = addr_q[ADDR_WIDTH-1:IDX_W];
  assign accept     = bus.req_valid && bus.req_ready;
  assign evict_done = evict_valid_q && bus.evict_ready;
  assign hit        = |hit_vec;
  assign hit_line   = lines_q[idx][hit_way];
  assign hand_line  = lines_q[idx][hand_q[idx]];

  // Flatten the indexed set into per-way vectors and locate the hitting way.
  always_comb begin
    valid_vec = '0;
    dirty_vec = '0;
    ref_vec   = '0;
    hit_vec   = '0;
    hit_way   = '0;
    for (int w = 0; w < K; w++) begin
      valid_vec[w] = lines_q[idx][w].valid;
      dirty_vec[w] = lines_q[idx][w].dirty;
      ref_vec[w]   = lines_q[idx][w].rbit;
      hit_vec[w]   = lines_q[idx][w].valid && (lines_q[idx][w].tag == tag);
      if (hit_vec[w]) hit_way = HAND_W'(w);
    end
  end

  // A freshly allocated line is valid, dirty and recently referenced.
  always_comb begin
    fill_line       = '0;
    fill_line.tag   = tag;
    fill_line.val   = val_q;
    fill_line.valid = 1'b1;
    fill_line.dirty = 1'b1;
    fill_line.rbit  = 1'b1;
  end

  clock_victim_sel #(.K(K), .HAND_W(HAND_W)) u_victim_sel (
    .ref_i          (ref_vec),
    .valid_i        (valid_vec),
    .dirty_i        (dirty_vec),
    .hand_i         (hand_q[idx]),
    .first_inv_o    (first_inv),
    .any_inv_o      (any_inv),
    .victim_found_o (victim_found),
    .victim_dirty_o (victim_dirty),
    .next_hand_o    (next_hand)
  );

  // Controller next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = LOOKUP;
      LOOKUP: begin
        state_d = IDLE;
        if (op_q == OP_WRITE && !hit && !any_inv) state_d = SWEEP;
        if (op_q == OP_INVAL && hit && hit_line.dirty) state_d = EVICT;
      end
      SWEEP:  if (victim_found) state_d = victim_dirty ? EVICT : IDLE;
      EVICT:  if (evict_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage, request latch, responses and write-back registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      op_q          <= OP_READ;
      addr_q        <= '0;
      val_q         <= '0;
      ready_en_q    <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      out_val_q     <= '0;
      evict_valid_q <= 1'b0;
      evict_addr_q  <= '0;
      evict_val_q   <= '0;
      victim_q      <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        hand_q[s] <= '0;
        for (int w = 0; w < K; w++) lines_q[s][w] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ready_en_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      if (accept) begin
        op_q   <= decode_op(bus.req_op);
        addr_q <= bus.in_addr;
        val_q  <= bus.in_val;
      end
      case (state_q)
        LOOKUP: begin
          case (op_q)
            OP_READ: begin
              resp_valid_q <= 1'b1;
              resp_hit_q   <= hit;
              out_val_q    <= hit ? hit_line.val : '0;
              if (hit) lines_q[idx][hit_way].rbit <= 1'b1;
            end
            OP_WRITE: begin
              if (hit) begin
                lines_q[idx][hit_way].val   <= val_q;
                lines_q[idx][hit_way].dirty <= 1'b1;
                lines_q[idx][hit_way].rbit  <= 1'b1;
                resp_valid_q <= 1'b1;
                resp_hit_q   <= 1'b1;
                out_val_q    <= '0;
              end else if (any_inv) begin
                lines_q[idx][first_inv] <= fill_line;
                resp_valid_q <= 1'b1;
                resp_hit_q   <= 1'b0;
                out_val_q    <= '0;
              end
            end
            OP_INVAL: begin
              if (hit && hit_line.dirty) begin
                evict_valid_q <= 1'b1;
                evict_addr_q  <= {hit_line.tag, idx};
                evict_val_q   <= hit_line.val;
                victim_q      <= hit_way;
              end else begin
                if (hit) begin
                  lines_q[idx][hit_way].valid <= 1'b0;
                  lines_q[idx][hit_way].dirty <= 1'b0;
                  lines_q[idx][hit_way].rbit  <= 1'b0;
                end
                resp_valid_q <= 1'b1;
                resp_hit_q   <= hit;
                out_val_q    <= '0;
              end
            end
            default: ;
          endcase
        end
        SWEEP: begin
          if (!victim_found) begin
            lines_q[idx][hand_q[idx]].rbit <= 1'b0;
            hand_q[idx] <= next_hand;
          end else if (!victim_dirty) begin
            lines_q[idx][hand_q[idx]] <= fill_line;
            hand_q[idx]  <= next_hand;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            out_val_q    <= '0;
          end else begin
            evict_valid_q <= 1'b1;
            evict_addr_q  <= {hand_line.tag, idx};
            evict_val_q   <= hand_line.val;
            victim_q      <= hand_q[idx];
          end
        end
        EVICT: begin
          if (evict_done) begin
            evict_valid_q <= 1'b0;
            if (op_q == OP_WRITE) begin
              lines_q[idx][victim_q] <= fill_line;
              hand_q[idx] <= next_hand;
            end else begin
              lines_q[idx][victim_q].valid <= 1'b0;
              lines_q[idx][victim_q].dirty <= 1'b0;
              lines_q[idx][victim_q].rbit  <= 1'b0;
            end
            resp_valid_q <= 1'b1;
            resp_hit_q   <= (op_q != OP_WRITE);
            out_val_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE) && ready_en_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = resp_hit_q;
  assign bus.out_val     = out_val_q;
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_addr  = evict_addr_q;
  assign bus.evict_val   = evict_val_q;
  assign bus.dbg_state   = state_q;

endmodule
